// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from the icache into a small
// circular buffer that decode drains; supports redirect and a sticky halt.
module fetch_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  output logic [WORD_W-1:0]          imemaddr,
  output logic                       imemREN,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  input  logic                       deq,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic                       valid,
  output logic [WORD_W-1:0]          instr,
  output logic [WORD_W-1:0]          instr_pc_plus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALTED} state_e;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       pc_q, pc_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [2*WORD_W-1:0]     mem_q [DEPTH];

  logic                    enq;
  logic                    deq_fire;
  logic [WORD_W-1:0]       pc_plus4;

  assign pc_plus4 = pc_q + WORD_W'(4);
  assign imemaddr = pc_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign valid    = (count_q != '0);
  assign instr         = valid ? mem_q[rd_ptr_q][2*WORD_W-1:WORD_W] : '0;
  assign instr_pc_plus = valid ? mem_q[rd_ptr_q][WORD_W-1:0] : '0;

  // Fetch is gated by nRST so no request is issued while reset is held.
  always_comb begin
    imemREN  = nRST && (state_q == RUN) && !full && !redirect;
    enq      = imemREN && ihit;
    deq_fire = deq && valid && !redirect;

    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (redirect) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (state_q == RUN && halt) state_d = HALTED;
      if (enq) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= RUN;
      pc_q     <= PC_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through valid.
  always_ff @(posedge CLK) begin
    if (nRST && enq) mem_q[wr_ptr_q] <= {imemload, pc_plus4};
  end

endmodule
